// File: rtl/alu_74181_pkg.sv
// Shared constants and operand-term helpers for the registered 74181-style ALU.
package alu_74181_pkg;

    typedef enum logic {
        M_ARITH = 1'b0,
        M_LOGIC = 1'b1
    } mode_e;

    localparam logic [3:0] S_PASS_A = 4'b0000;
    localparam logic [3:0] S_NOR    = 4'b0001;
    localparam logic [3:0] S_ZERO   = 4'b0011;
    localparam logic [3:0] S_SUB    = 4'b0110;
    localparam logic [3:0] S_ADD    = 4'b1001;
    localparam logic [3:0] S_DEC_A  = 4'b1111;

    // T1 acts as per-bit propagate and T2 as per-bit generate; T2 implies T1.
    function automatic logic [3:0] t1_fn(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] s);
        return a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    endfunction

    function automatic logic [3:0] t2_fn(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] s);
        return (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
    endfunction

endpackage

// File: rtl/alu_74181_cla.sv
// Four-bit carry-lookahead: internal carries, active-low carry-out and group P/G.
module alu_74181_cla (
    input  logic [3:0] t1,
    input  logic [3:0] t2,
    input  logic       c_n,
    output logic [3:0] carry,
    output logic       c_nplus4,
    output logic       final_p,
    output logic       final_g
);

    logic c0;
    logic grp_g;
    logic grp_p;

    always_comb begin
        c0       = ~c_n;
        carry[0] = c0;
        carry[1] = t2[0] | (t1[0] & c0);
        carry[2] = t2[1] | (t1[1] & t2[0]) | (t1[1] & t1[0] & c0);
        carry[3] = t2[2] | (t1[2] & t2[1]) | (t1[2] & t1[1] & t2[0])
                 | (t1[2] & t1[1] & t1[0] & c0);
        grp_g    = t2[3] | (t1[3] & t2[2]) | (t1[3] & t1[2] & t2[1])
                 | (t1[3] & t1[2] & t1[1] & t2[0]);
        grp_p    = &t1;
        c_nplus4 = ~(grp_g | (grp_p & c0));
        final_p  = ~grp_p;
        final_g  = ~grp_g;
    end

endmodule

// File: rtl/alu_74181.sv
// Registered 74181-style ALU with one-cycle latency.
// Define ALU_74181_EQ_EN to enable the eq comparator; otherwise eq is tied low.
module alu_74181
    import alu_74181_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [3:0] S,
    input  logic       M,
    input  logic       C_n,
    input  logic       in_valid,
    output logic [3:0] F,
    output logic       C_nplus4,
    output logic       finalP,
    output logic       finalG,
    output logic       eq,
    output logic       out_valid
);

    logic [3:0] t1, t2, carry, half, f_res;
    logic       cn4, fp, fg;
    logic [3:0] f_d, f_q;
    logic       cn4_d, cn4_q, p_d, p_q, g_d, g_q, out_valid_d, out_valid_q;

    always_comb begin
        t1 = t1_fn(A, B, S);
        t2 = t2_fn(A, B, S);
    end

    alu_74181_cla u_cla (
        .t1       (t1),
        .t2       (t2),
        .c_n      (C_n),
        .carry    (carry),
        .c_nplus4 (cn4),
        .final_p  (fp),
        .final_g  (fg)
    );

    // Since T2 implies T1, T1^T2 is the half-sum; adding the carry gives T1+T2+cin.
    always_comb begin
        half        = t1 ^ t2;
        f_res       = (mode_e'(M) == M_LOGIC) ? ~half : (half ^ carry);
        f_d         = f_q;
        cn4_d       = cn4_q;
        p_d         = p_q;
        g_d         = g_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            f_d   = f_res;
            cn4_d = cn4;
            p_d   = fp;
            g_d   = fg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q         <= '0;
            cn4_q       <= 1'b1;
            p_q         <= 1'b1;
            g_q         <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            f_q         <= f_d;
            cn4_q       <= cn4_d;
            p_q         <= p_d;
            g_q         <= g_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef ALU_74181_EQ_EN
    logic eq_d, eq_q;

    always_comb begin
        eq_d = eq_q;
        if (in_valid) begin
            eq_d = &f_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eq_q <= 1'b0;
        end else begin
            eq_q <= eq_d;
        end
    end

    assign eq = eq_q;
`else
    assign eq = 1'b0;
`endif

    assign F         = f_q;
    assign C_nplus4  = cn4_q;
    assign finalP    = p_q;
    assign finalG    = g_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_74181.sv
// Self-checking bench for alu_74181: arithmetic reference model plus directed literals.
module tb_alu_74181;
    import alu_74181_pkg::*;

`ifdef ALU_74181_EQ_EN
    localparam bit EQ_ON = 1'b1;
`else
    localparam bit EQ_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] A = '0, B = '0, S = '0;
    logic       M = 1'b0, C_n = 1'b1, in_valid = 1'b0;
    logic [3:0] F;
    logic       C_nplus4, finalP, finalG, eq, out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [3:0] f;
        logic       cn4;
        logic       p;
        logic       g;
        logic       eq;
    } res_t;

    localparam res_t RST_VAL = '{f: 4'h0, cn4: 1'b1, p: 1'b1, g: 1'b1, eq: 1'b0};

    res_t exp_r  = RST_VAL;
    logic exp_ov = 1'b0;

    always #5 clk = ~clk;

    alu_74181 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .S         (S),
        .M         (M),
        .C_n       (C_n),
        .in_valid  (in_valid),
        .F         (F),
        .C_nplus4  (C_nplus4),
        .finalP    (finalP),
        .finalG    (finalG),
        .eq        (eq),
        .out_valid (out_valid)
    );

    // Reference: integer sums of the two per-bit terms, no lookahead structure.
    function automatic res_t model(input logic [3:0] a, input logic [3:0] b,
                                   input logic [3:0] s, input logic m, input logic cn);
        int   t1 = 0;
        int   t2 = 0;
        int   sum;
        res_t r;
        for (int i = 0; i < 4; i++) begin
            if (a[i] || (b[i] && s[0]) || (!b[i] && s[1])) t1 += (1 << i);
            if ((a[i] && !b[i] && s[2]) || (a[i] && b[i] && s[3])) t2 += (1 << i);
        end
        sum   = t1 + t2 + (cn ? 0 : 1);
        r.f   = m ? 4'(~(t1 ^ t2)) : 4'(sum);
        r.cn4 = !(sum > 15);
        r.p   = !(t1 == 15);
        r.g   = !((t1 + t2) > 15);
        r.eq  = EQ_ON && (r.f == 4'hf);
        return r;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_r  <= RST_VAL;
            exp_ov <= 1'b0;
        end else begin
            exp_ov <= in_valid;
            if (in_valid) exp_r <= model(A, B, S, M, C_n);
        end
    end

    always @(posedge clk) begin
        #1;
        chk("F", F, exp_r.f);
        chk("C_nplus4", 4'(C_nplus4), 4'(exp_r.cn4));
        chk("finalP", 4'(finalP), 4'(exp_r.p));
        chk("finalG", 4'(finalG), 4'(exp_r.g));
        chk("eq", 4'(eq), 4'(exp_r.eq));
        chk("out_valid", 4'(out_valid), 4'(exp_ov));
    end

    task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s,
                         input logic m, input logic cn);
        @(negedge clk);
        A = a; B = b; S = s; M = m; C_n = cn; in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_F"}, F, 4'h0);
        chk({tag, "_cn4"}, 4'(C_nplus4), 4'd1);
        chk({tag, "_P"}, 4'(finalP), 4'd1);
        chk({tag, "_G"}, 4'(finalG), 4'd1);
        chk({tag, "_eq"}, 4'(eq), 4'd0);
        chk({tag, "_ov"}, 4'(out_valid), 4'd0);
    endtask

    initial begin
        logic [3:0] pa [5] = '{4'h0, 4'hf, 4'h9, 4'h7, 4'h3};
        logic [3:0] pb [5] = '{4'h0, 4'hf, 4'h6, 4'hc, 4'ha};

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;

        apply(4'b0001, 4'b0011, S_ADD, M_ARITH, 1'b1);
        chk("add_F", F, 4'b0100);
        chk("add_cn4", 4'(C_nplus4), 4'd1);
        chk("add_eq", 4'(eq), 4'd0);
        chk("add_ov", 4'(out_valid), 4'd1);

        @(negedge clk);
        in_valid = 1'b0; A = 4'hc; S = S_ZERO;
        @(posedge clk);
        #1;
        chk("hold_F", F, 4'b0100);
        chk("hold_ov", 4'(out_valid), 4'd0);

        apply(4'b0001, 4'b0011, S_PASS_A, M_LOGIC, 1'b1);
        chk("notA_F", F, 4'b1110);
        apply(4'b0001, 4'b0011, S_NOR, M_LOGIC, 1'b1);
        chk("nor_F", F, 4'b1100);
        apply(4'b0001, 4'b0011, 4'b0010, M_ARITH, 1'b1);
        chk("aornb_F", F, 4'b1101);

        apply(4'b0101, 4'b0101, S_SUB, M_ARITH, 1'b1);
        chk("sub_F", F, 4'b1111);
        chk("sub_eq", 4'(eq), 4'(EQ_ON));
        chk("sub_cn4", 4'(C_nplus4), 4'd1);
        chk("sub_P", 4'(finalP), 4'd0);
        chk("sub_G", 4'(finalG), 4'd1);

        apply(4'b0001, 4'b0000, S_DEC_A, M_ARITH, 1'b1);
        chk("dec_F", F, 4'b0000);
        chk("dec_cn4", 4'(C_nplus4), 4'd0);
        chk("dec_G", 4'(finalG), 4'd0);
        chk("dec_eq", 4'(eq), 4'd0);

        apply(4'h9, 4'h6, S_ZERO, M_LOGIC, 1'b0);
        chk("zero_F", F, 4'h0);
        apply(4'hf, 4'h1, S_ADD, M_ARITH, 1'b0);
        chk("addc_F", F, 4'h1);
        chk("addc_cn4", 4'(C_nplus4), 4'd0);

        for (int k = 0; k < 5; k++) begin
            for (int s = 0; s < 16; s++) begin
                for (int m = 0; m < 2; m++) begin
                    for (int c = 0; c < 2; c++) begin
                        @(negedge clk);
                        A = pa[k]; B = pb[k]; S = 4'(s); M = m[0]; C_n = c[0];
                        in_valid = ((s + 2 * m + c) % 7 == 3) ? 1'b0 : 1'b1;
                        @(posedge clk);
                        #1;
                        if (in_valid && m == 0 && S == S_ADD)
                            chk("sweep_add", F, 4'(pa[k] + pb[k] + (c == 0 ? 4'd1 : 4'd0)));
                        if (in_valid && m == 0 && S == S_SUB)
                            chk("sweep_sub", F, 4'(pa[k] - pb[k] - 4'd1 + (c == 0 ? 4'd1 : 4'd0)));
                    end
                end
            end
        end

        @(negedge clk);
        A = 4'h9; B = 4'h6; S = S_ADD; M = M_ARITH; C_n = 1'b1; in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("midrst");
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ov", 4'(out_valid), 4'd0);
        chk("post_rst_F", F, 4'h0);

        apply(4'h9, 4'h6, S_ADD, M_ARITH, 1'b1);
        chk("first_after_rst_F", F, 4'hf);
        chk("first_after_rst_ov", 4'(out_valid), 4'd1);

        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_74181.md
ALU_74181 -- requirements
Module: alu_74181

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (rising edge) and rst_n.
REQ-002 clk  input  1  clock; all outputs are registered on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 A  input  4  operand A, active-high data.
REQ-005 B  input  4  operand B, active-high data.
REQ-006 S  input  4  function select S[3:0].
REQ-007 M  input  1  mode: 1 = logic, 0 = arithmetic.
REQ-008 C_n  input  1  carry-in, active-low (1 = no carry).
REQ-009 in_valid  input  1  operands valid this cycle.
REQ-010 F  output  4  registered result.
REQ-011 C_nplus4  output  1  registered carry-out, active-low.
REQ-012 finalP  output  1  registered group propagate, active-low.
REQ-013 finalG  output  1  registered group generate, active-low.
REQ-014 eq  output  1  registered A=B flag (all F bits 1).
REQ-015 out_valid  output  1  registered; high one cycle after an accepted in_valid.

Function
REQ-016 Per bit i: T1_i = A_i | (B_i & S0) | (~B_i & S1); T2_i = (A_i & ~B_i & S2) | (A_i & B_i & S3).
REQ-017 Arithmetic (M=0): F = (T1 + T2 + ~C_n) mod 16; C_nplus4 = inverse of carry out of bit 3.
REQ-018 Logic (M=1): F = ~(T1 ^ T2); C_n ignored for F.
REQ-019 C_nplus4 SHALL be computed by the arithmetic path in both modes.
REQ-020 finalP = ~(T1_3 & T1_2 & T1_1 & T1_0); finalG = ~(T2_3 | T1_3&T2_2 | T1_3&T1_2&T2_1 | T1_3&T1_2&T1_1&T2_0); both independent of M and C_n.
REQ-021 eq = &F of the same result.
REQ-022 Resulting table (M=1 / M=0,C_n=1): 0000 ~A / A; 0001 ~(A|B) / A|B; 0010 ~A&B / A|~B; 0011 0 / minus 1; 0100 ~(A&B) / A plus A&~B; 0101 ~B / (A|B) plus A&~B; 0110 A^B / A minus B minus 1; 0111 A&~B / (A&~B) minus 1; 1000 ~A|B / A plus A&B; 1001 ~(A^B) / A plus B; 1010 B / (A|~B) plus A&B; 1011 A&B / (A&B) minus 1; 1100 1111 / A plus A; 1101 A|~B / (A|B) plus A; 1110 A|B / (A|~B) plus A; 1111 A / A minus 1. C_n=0 adds 1.
REQ-023 Latency: exactly one clk cycle from in_valid to registered outputs; full throughput, one operation per cycle.
REQ-024 When in_valid=0, F, C_nplus4, finalP, finalG, eq SHALL hold; out_valid deasserts next cycle.
REQ-025 Arithmetic wraps mod 16 with carry reported only on C_nplus4.

Reset
REQ-026 On rst_n low, immediately: F=0000, C_nplus4=1, finalP=1, finalG=1, eq=0, out_valid=0.
REQ-027 Reset asserted mid-operation SHALL discard the in-flight result; first valid output follows the first in_valid after release.

Configuration
REQ-028 Macro ALU_74181_EQ_EN: defined -> eq per REQ-021; undefined -> eq port present, tied to 0, comparator logic omitted.

Structure
REQ-029 Package alu_74181_pkg SHALL hold 4-bit S function-code constants (e.g. S_PASS_A=0000, S_SUB=0110, S_ADD=1001, S_DEC_A=1111) and mode constants M_LOGIC=1, M_ARITH=0.
REQ-030 One sub-module alu_74181_cla SHALL compute internal carries, C_nplus4, finalP, finalG from T1, T2, C_n; the top holds T1/T2 generation, F mux and output registers.

Verification
REQ-031 A=0001,B=0011,C_n=1,M=0,S=1001 -> next cycle F=0100, C_nplus4=1, eq=0.
REQ-032 A=0001,B=0011,C_n=1: M=1,S=0000 -> F=1110; M=1,S=0001 -> F=1100; M=0,S=0010 -> F=1101.
REQ-033 A=0101,B=0101,C_n=1,M=0,S=0110 -> F=1111, eq=1, C_nplus4=1, finalP=0, finalG=1.
REQ-034 A=0001,C_n=1,M=0,S=1111 -> F=0000, C_nplus4=0, finalG=0, eq=0.
REQ-035 Assert rst_n low while in_valid=1 -> outputs take reset values in the same cycle; in_valid=0 after release -> out_valid stays 0, F holds 0000.
